uart_tx_arbiter: RTL

- Shares the single UART byte transmitter among NUM_REQ on-chip requesters, e.g. CPU debug port, memory-dump engine and status reporter.
- Each requester offers bytes through a valid/ready handshake and marks its last byte with req_last. A multi-byte packet is sent without being interleaved with other requesters.
- Round-robin arbitration applies between packets.
- The block drives the transmitter's start/data inputs, watches its busy flag, and applies launch and lock timeouts.

---
 rtl/uart_tx_arbiter.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Purpose: shares one UART byte transmitter among NUM_REQ requesters.
//   Packets are never interleaved; round-robin arbitration between packets.
//   A launch timeout guards tx_start; a lock timeout frees a stalled owner.
// Ports:
//   clk, rst              clock, async active-high reset
//   req_valid/data/last   per-requester byte offer (data is 8*NUM_REQ wide)
//   req_ready             one-hot, 1-cycle accept pulse
//   tx_start/tx_data      transmitter launch request and byte
//   tx_busy               transmitter is sending a frame
//   grant_id, locked      current/last owner, packet in progress
//   err_launch, err_lock  1-cycle timeout pulses
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 3,
    parameter int LAUNCH_TIMEOUT = 1024,
    parameter int LOCK_TIMEOUT   = 65535,
    localparam int IDW           = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    output logic [IDW-1:0]       grant_id,
    output logic                 locked,
    output logic                 err_launch,
    output logic                 err_lock
);

    localparam int LCW = $clog2(LAUNCH_TIMEOUT + 1);
    localparam int LKW = $clog2(LOCK_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_BUSY
    } state_t;

    state_t             state_q, state_d;
    logic               tx_start_q, tx_start_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
    logic [IDW-1:0]     grant_q, grant_d;
    logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
    logic               locked_q, locked_d;
    logic               err_launch_q, err_launch_d;
    logic               err_lock_q, err_lock_d;
    logic [LCW-1:0]     launch_cnt_q, launch_cnt_d;
    logic [LKW-1:0]     lock_cnt_q, lock_cnt_d;

    logic               own_valid;
    logic               win_found;
    logic [IDW-1:0]     win_idx;
    logic [7:0]         win_data;
    logic               win_last;
    int                 scan_idx;

    always_comb begin
        own_valid = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q == IDW'(i)) begin
                own_valid = req_valid[i];
            end
        end
    end

    // While locked only the owner is eligible; otherwise scan upward
    // from the slot after the last finished packet, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = 0;
        if (locked_q) begin
            win_found = own_valid;
            win_idx   = grant_q;
        end else begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                scan_idx = int'(rr_ptr_q) + k;
                if (scan_idx >= NUM_REQ) begin
                    scan_idx = scan_idx - NUM_REQ;
                end
                if (!win_found && req_valid[scan_idx[IDW-1:0]]) begin
                    win_found = 1'b1;
                    win_idx   = scan_idx[IDW-1:0];
                end
            end
        end
    end

    always_comb begin
        win_data = '0;
        win_last = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == IDW'(i)) begin
                win_data = req_data[8*i +: 8];
                win_last = req_last[i];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        tx_start_d   = tx_start_q;
        tx_data_d    = tx_data_q;
        req_ready_d  = '0;
        grant_d      = grant_q;
        rr_ptr_d     = rr_ptr_q;
        locked_d     = locked_q;
        err_launch_d = 1'b0;
        err_lock_d   = 1'b0;
        launch_cnt_d = launch_cnt_q;
        lock_cnt_d   = lock_cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    req_ready_d = NUM_REQ'(1) << win_idx;
                    tx_data_d   = win_data;
                    grant_d     = win_idx;
                    lock_cnt_d  = '0;
                    state_d     = S_LAUNCH;
                    if (win_last) begin
                        locked_d = 1'b0;
                        rr_ptr_d = win_idx;
                    end else begin
                        locked_d = 1'b1;
                    end
                end else if (locked_q) begin
                    // Owner is idle: count towards releasing the lock.
                    if (lock_cnt_q == LKW'(LOCK_TIMEOUT - 1)) begin
                        locked_d   = 1'b0;
                        rr_ptr_d   = grant_q;
                        err_lock_d = 1'b1;
                        lock_cnt_d = '0;
                    end else begin
                        lock_cnt_d = lock_cnt_q + 1'b1;
                    end
                end
            end
            S_LAUNCH: begin
                // tx_busy only counts once start is actually on the wire,
                // so a frame still draining is not mistaken for ours.
                if (!tx_start_q) begin
                    tx_start_d = 1'b1;
                end else if (tx_busy) begin
                    tx_start_d   = 1'b0;
                    launch_cnt_d = '0;
                    state_d      = S_BUSY;
                end else if (launch_cnt_q == LCW'(LAUNCH_TIMEOUT - 1)) begin
                    tx_start_d   = 1'b0;
                    err_launch_d = 1'b1;
                    launch_cnt_d = '0;
                    state_d      = S_IDLE;
                end else begin
                    launch_cnt_d = launch_cnt_q + 1'b1;
                end
            end
            S_BUSY: begin
                if (!tx_busy) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            tx_start_q   <= 1'b0;
            tx_data_q    <= '0;
            req_ready_q  <= '0;
            grant_q      <= '0;
            rr_ptr_q     <= IDW'(NUM_REQ - 1);
            locked_q     <= 1'b0;
            err_launch_q <= 1'b0;
            err_lock_q   <= 1'b0;
            launch_cnt_q <= '0;
            lock_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            tx_start_q   <= tx_start_d;
            tx_data_q    <= tx_data_d;
            req_ready_q  <= req_ready_d;
            grant_q      <= grant_d;
            rr_ptr_q     <= rr_ptr_d;
            locked_q     <= locked_d;
            err_launch_q <= err_launch_d;
            err_lock_q   <= err_lock_d;
            launch_cnt_q <= launch_cnt_d;
            lock_cnt_q   <= lock_cnt_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign tx_start   = tx_start_q;
    assign tx_data    = tx_data_q;
    assign grant_id   = grant_q;
    assign locked     = locked_q;
    assign err_launch = err_launch_q;
    assign err_lock   = err_lock_q;

endmodule
